// File: rtl/adc_idelay_load_seq.sv
// Sequences IODELAYE1 VAR_LOADABLE tap loads over the masked ADC lanes on each commit-bit toggle
// and reports progress and results in a readback status word.
module adc_idelay_load_seq #(
    parameter int N_LANES       = 16,
    parameter int TAP_W         = 5,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic               user_clk,
    input  logic               user_rst_n,
    input  logic [31:0]        cfg_word,
    input  logic               idelayctrl_rdy,
    output logic [TAP_W-1:0]   dly_cntvalue,
    output logic [N_LANES-1:0] dly_ld,
    output logic               busy,
    output logic [31:0]        status
);

    localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_LANES - 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]         state;
    logic               cfg_q_commit;
    logic               commit;
    logic [N_LANES-1:0] mask;
    logic [N_LANES-1:0] loaded;
    logic [N_LANES-1:0] loaded_last;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               pending;
    logic               overrun;
    logic [4:0]         last_tap;
    logic [7:0]         pass_cnt;
    logic               unused_cfg;

    // Only some cfg_word fields are consumed, depending on the lane count.
    assign unused_cfg = ^cfg_word;

    assign commit = cfg_word[8] ^ cfg_q_commit;

    always_ff @(posedge user_clk) begin
        // The commit reference tracks cfg_word even in reset, so a toggle made
        // while reset is held is absorbed rather than starting a pass.
        cfg_q_commit <= cfg_word[8];
        if (!user_rst_n) begin
            state        <= S_IDLE;
            dly_ld       <= '0;
            dly_cntvalue <= '0;
            busy         <= 1'b0;
            mask         <= '0;
            loaded       <= '0;
            loaded_last  <= '0;
            idx          <= '0;
            cnt          <= '0;
            pending      <= 1'b0;
            overrun      <= 1'b0;
            last_tap     <= '0;
            pass_cnt     <= '0;
        end else begin
            // NOTE: this default is overridden by a later non-blocking write in the
            // same cycle, which keeps dly_ld a one-cycle pulse without extra state.
            dly_ld <= '0;

            if (commit && state != S_IDLE && pending)
                overrun <= 1'b1;
            else if (cfg_word[9])
                overrun <= 1'b0;

            if (state == S_DONE)
                pending <= 1'b0;
            else if (commit && state != S_IDLE)
                pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (commit) begin
                        mask         <= cfg_word[16 +: N_LANES];
                        dly_cntvalue <= cfg_word[TAP_W-1:0];
                        idx          <= '0;
                        busy         <= 1'b1;
                        state        <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!mask[idx]) begin
                        if (idx == LAST_IDX)
                            state <= S_DONE;
                        else
                            idx <= idx + 1'b1;
                    end else if (idelayctrl_rdy) begin
                        dly_ld[idx] <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    loaded[idx] <= 1'b1;
                    cnt         <= SETTLE_INIT;
                    state       <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (idx == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_SCAN;
                    end
                end
                S_DONE: begin
                    loaded_last <= loaded;
                    last_tap    <= 5'(dly_cntvalue);
                    pass_cnt    <= pass_cnt + 1'b1;
                    loaded      <= '0;
                    // A commit landing on this cycle is served here, same as a queued one.
                    if (pending || commit) begin
                        mask         <= cfg_word[16 +: N_LANES];
                        dly_cntvalue <= cfg_word[TAP_W-1:0];
                        idx          <= '0;
                        state        <= S_SCAN;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        status                   = '0;
        status[0]                = busy;
        status[1]                = pending;
        status[2]                = overrun;
        status[7:3]              = last_tap;
        status[15:8]             = pass_cnt;
        status[16 +: N_LANES]    = loaded_last;
    end

endmodule

// File: tb/tb_adc_idelay_load_seq.sv
// Self-checking bench for adc_idelay_load_seq: a lane-pointer/timeline model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_adc_idelay_load_seq;

    localparam int N_LANES = 16;
    localparam int TAP_W   = 5;
    localparam int SETTLE  = 8;

    logic               user_clk = 1'b0;
    logic               user_rst_n;
    logic [31:0]        cfg_word;
    logic               idelayctrl_rdy;
    logic [TAP_W-1:0]   dly_cntvalue;
    logic [N_LANES-1:0] dly_ld;
    logic               busy;
    logic [31:0]        status;

    int checks = 0;
    int errors = 0;
    int ld_seen = 0;

    adc_idelay_load_seq #(
        .N_LANES      (N_LANES),
        .TAP_W        (TAP_W),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .user_clk      (user_clk),
        .user_rst_n    (user_rst_n),
        .cfg_word      (cfg_word),
        .idelayctrl_rdy(idelayctrl_rdy),
        .dly_cntvalue  (dly_cntvalue),
        .dly_ld        (dly_ld),
        .busy          (busy),
        .status        (status)
    );

    always #5 user_clk = ~user_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: a pass is a lane pointer plus the cycle of its next decision
    bit          model_valid = 1'b0;
    bit          active      = 1'b0;
    int          cyc         = 0;
    int          lane;
    int          t_next;
    logic [15:0] p_mask;
    logic [15:0] p_loaded;
    logic [4:0]  p_tap;
    logic        m_cfg8;
    logic [15:0] m_ld;
    logic [4:0]  m_tap_out;
    logic        m_busy;
    logic        m_pending;
    logic        m_overrun;
    logic [7:0]  m_pass;
    logic [4:0]  m_last_tap;
    logic [15:0] m_loaded_last;

    task automatic model_start();
        p_mask    = cfg_word[31:16];
        p_tap     = cfg_word[4:0];
        m_tap_out = p_tap;
        lane      = 0;
        t_next    = cyc + 1;
    endtask

    always @(posedge user_clk) begin
        bit commit;
        bit ovr_set;
        bit done;
        commit  = (cfg_word[8] != m_cfg8);
        m_cfg8  = cfg_word[8];
        m_ld    = '0;
        ovr_set = 1'b0;
        done    = 1'b0;
        if (!user_rst_n) begin
            active        = 1'b0;
            m_busy        = 1'b0;
            m_pending     = 1'b0;
            m_overrun     = 1'b0;
            m_pass        = '0;
            m_last_tap    = '0;
            m_loaded_last = '0;
            m_tap_out     = '0;
            p_loaded      = '0;
            model_valid   = 1'b1;
        end else if (!active) begin
            if (commit) begin
                model_start();
                active = 1'b1;
                m_busy = 1'b1;
            end
            if (cfg_word[9]) m_overrun = 1'b0;
        end else begin
            ovr_set = commit && m_pending;
            if (cyc == t_next) begin
                if (lane == N_LANES) begin
                    done          = 1'b1;
                    m_loaded_last = p_loaded;
                    m_last_tap    = p_tap;
                    m_pass        = m_pass + 8'd1;
                    p_loaded      = '0;
                    if (m_pending || commit) begin
                        m_pending = 1'b0;
                        model_start();
                    end else begin
                        active = 1'b0;
                        m_busy = 1'b0;
                    end
                end else if (!p_mask[lane]) begin
                    lane++;
                    t_next = cyc + 1;
                end else if (idelayctrl_rdy) begin
                    m_ld[lane]     = 1'b1;
                    p_loaded[lane] = 1'b1;
                    lane++;
                    t_next = cyc + 2 + SETTLE;
                end else begin
                    t_next = cyc + 1;
                end
            end
            if (commit && !done) m_pending = 1'b1;
            if (ovr_set) m_overrun = 1'b1;
            else if (cfg_word[9]) m_overrun = 1'b0;
        end
        cyc++;
    end

    always @(negedge user_clk) begin
        if (model_valid) begin
            check("model_dly_ld", 32'(dly_ld), 32'(m_ld));
            check("model_cntvalue", 32'(dly_cntvalue), 32'(m_tap_out));
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_status", status,
                  {m_loaded_last, m_pass, m_last_tap, m_overrun, m_pending, m_busy});
            if (dly_ld != '0) ld_seen++;
        end
    end

    // ---------------- stimulus
    // NOTE: inputs change 2 time units after the rising edge, so the DUT and the
    // model both sample settled values and outputs are read away from the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge user_clk);
            #2;
        end
    endtask

    task automatic commit_pass(input logic [15:0] mask, input logic [4:0] tap);
        cfg_word[31:16] = mask;
        cfg_word[4:0]   = tap;
        cfg_word[8]     = ~cfg_word[8];
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        step(1);
        while (busy && n < budget) begin
            step(1);
            n++;
        end
        check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        user_rst_n     = 1'b0;
        cfg_word       = '0;
        idelayctrl_rdy = 1'b1;
        step(3);
        check("rst_status", status, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dly_ld", 32'(dly_ld), 32'd0);
        check("rst_cntvalue", 32'(dly_cntvalue), 32'd0);
        user_rst_n = 1'b1;
        step(3);

        // 1: tap 17, lanes 0 and 2
        commit_pass(16'h0005, 5'd17);
        step(1);
        check("t1_cntvalue", 32'(dly_cntvalue), 32'd17);
        check("t1_busy_rise", 32'(busy), 32'd1);
        step(1);
        check("t1_ld_lane0", 32'(dly_ld), 32'h1);
        step(11);
        check("t1_ld_lane2", 32'(dly_ld), 32'h4);
        step(22);
        check("t1_busy_in_done", 32'(busy), 32'd1);
        step(1);
        check("t1_busy_fall", 32'(busy), 32'd0);
        check("t1_status", status, 32'h0005_0188);
        step(3);

        // 2: all lanes, tap 31
        commit_pass(16'hFFFF, 5'd31);
        step(2);
        for (int i = 0; i < 16; i++) begin
            check("t2_ld_lane", 32'(dly_ld), 32'd1 << i);
            if (i < 15) step(10);
        end
        wait_idle(200);
        check("t2_loaded", 32'(status[31:16]), 32'hFFFF);
        check("t2_pass_cnt", 32'(status[15:8]), 32'd2);
        check("t2_last_tap", 32'(status[7:3]), 32'd31);
        step(2);

        // 3: IDELAYCTRL not ready at commit
        idelayctrl_rdy = 1'b0;
        commit_pass(16'h0001, 5'd6);
        step(20);
        check("t3_no_ld_while_not_rdy", 32'(dly_ld), 32'd0);
        idelayctrl_rdy = 1'b1;
        step(1);
        check("t3_ld_after_rdy", 32'(dly_ld), 32'h1);
        wait_idle(100);
        check("t3_pass_cnt", 32'(status[15:8]), 32'd3);
        step(2);

        // 4: pending, overrun, re-pass from cfg_word at DONE, overrun clear
        commit_pass(16'h0003, 5'd5);
        step(5);
        cfg_word[8] = ~cfg_word[8];
        step(1);
        check("t4_pending", 32'(status[1]), 32'd1);
        step(2);
        cfg_word[8] = ~cfg_word[8];
        step(1);
        check("t4_overrun", 32'(status[2]), 32'd1);
        step(1);
        cfg_word[31:16] = 16'h0010;
        cfg_word[4:0]   = 5'd9;
        step(26);
        check("t4_first_loaded", 32'(status[31:16]), 32'h0003);
        check("t4_still_busy", 32'(busy), 32'd1);
        check("t4_pending_served", 32'(status[1]), 32'd0);
        check("t4_new_tap", 32'(dly_cntvalue), 32'd9);
        wait_idle(100);
        check("t4_second_loaded", 32'(status[31:16]), 32'h0010);
        check("t4_second_tap", 32'(status[7:3]), 32'd9);
        check("t4_pass_cnt", 32'(status[15:8]), 32'd5);
        check("t4_overrun_sticky", 32'(status[2]), 32'd1);
        cfg_word[9] = 1'b1;
        step(1);
        cfg_word[9] = 1'b0;
        check("t4_overrun_clear", 32'(status[2]), 32'd0);
        step(2);

        // 5: reset during SETTLE aborts; toggle under reset is ignored
        commit_pass(16'h0003, 5'd3);
        step(2);
        check("t5_ld_lane0", 32'(dly_ld), 32'h1);
        step(1);
        user_rst_n = 1'b0;
        step(1);
        check("t5_ld_cleared", 32'(dly_ld), 32'd0);
        check("t5_status_cleared", status, 32'h0);
        cfg_word[8] = ~cfg_word[8];
        step(2);
        ld_seen    = 0;
        user_rst_n = 1'b1;
        step(40);
        check("t5_no_pass", 32'(busy), 32'd0);
        check("t5_no_ld", 32'(ld_seen), 32'd0);

        // 6: 256 empty passes wrap the pass count
        ld_seen = 0;
        for (int i = 1; i <= 256; i++) begin
            commit_pass(16'h0000, 5'(i));
            wait_idle(60);
            if (i == 255) check("t6_count_255", 32'(status[15:8]), 32'd255);
        end
        check("t6_count_wrap", 32'(status[15:8]), 32'd0);
        check("t6_empty_loaded", 32'(status[31:16]), 32'd0);
        check("t6_no_ld", 32'(ld_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
